reg_file: RTL and testbench

//  Register bank for the microprocessor datapath: DEPTH words of WIDTH bits,
//  one write port and two independent registered read ports (A, B) for ALU

---
 rtl/reg_file_if.sv | 37 +++
 rtl/reg_file.sv | 111 +++++++++++
 tb/tb_reg_file.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// Bus bundle for the datapath register bank: one write port and two
// independent registered read ports (A, B). The master drives requests,
// the slave (reg_file) returns read data and valid strobes.
interface reg_file_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
);
    logic             WE;
    logic [AW-1:0]    WADDR;
    logic [WIDTH-1:0] WDATA;

    logic             RE_A;
    logic [AW-1:0]    RADDR_A;
    logic [WIDTH-1:0] RDATA_A;
    logic             RVALID_A;

    logic             RE_B;
    logic [AW-1:0]    RADDR_B;
    logic [WIDTH-1:0] RDATA_B;
    logic             RVALID_B;

    modport master (
        output WE, WADDR, WDATA,
        output RE_A, RADDR_A,
        output RE_B, RADDR_B,
        input  RDATA_A, RVALID_A,
        input  RDATA_B, RVALID_B
    );

    modport slave (
        input  WE, WADDR, WDATA,
        input  RE_A, RADDR_A,
        input  RE_B, RADDR_B,
        output RDATA_A, RVALID_A,
        output RDATA_B, RVALID_B
    );
endinterface

// File: rtl/reg_file.sv
// Register bank for the datapath: 2**AW words of WIDTH bits, one
// clock-enabled write port and two registered read ports with a one-cycle
// latency, a valid strobe per port and same-edge write-to-read forwarding.
// With ZERO_R0 set, word 0 is a constant zero: writes to it are dropped and
// reads of it (including forwarded ones) return zero.
module reg_file #(
    parameter int WIDTH   = 8,
    parameter int AW      = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic       CLK,
    input  logic       RST,
    reg_file_if.slave  bus
);
    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic [WIDTH-1:0] rdata_a_q, rdata_a_d;
    logic             rvalid_a_q, rvalid_a_d;
    logic [WIDTH-1:0] rdata_b_q, rdata_b_d;
    logic             rvalid_b_q, rvalid_b_d;

    logic             wr_blocked;
    logic             zero_a, zero_b;
    logic             fwd_a, fwd_b;

    // Decode which addresses are pinned to zero and which reads see the
    // write landing on the same edge.
    always_comb begin
        wr_blocked = (ZERO_R0 != 0) && (bus.WADDR == '0);
        zero_a     = (ZERO_R0 != 0) && (bus.RADDR_A == '0);
        zero_b     = (ZERO_R0 != 0) && (bus.RADDR_B == '0);
        fwd_a      = bus.WE && (bus.RADDR_A == bus.WADDR);
        fwd_b      = bus.WE && (bus.RADDR_B == bus.WADDR);
    end

    // Next memory contents: only the addressed word changes on a write.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (bus.WE && !wr_blocked) begin
            mem_d[bus.WADDR] = bus.WDATA;
        end
    end

    // Port A next state: data only moves on a request, valid mirrors RE.
    always_comb begin
        rdata_a_d  = rdata_a_q;
        rvalid_a_d = bus.RE_A;
        if (bus.RE_A) begin
            if (zero_a) begin
                rdata_a_d = '0;
            end else if (fwd_a) begin
                rdata_a_d = bus.WDATA;
            end else begin
                rdata_a_d = mem_q[bus.RADDR_A];
            end
        end
    end

    // Port B next state: identical to port A, fully independent.
    always_comb begin
        rdata_b_d  = rdata_b_q;
        rvalid_b_d = bus.RE_B;
        if (bus.RE_B) begin
            if (zero_b) begin
                rdata_b_d = '0;
            end else if (fwd_b) begin
                rdata_b_d = bus.WDATA;
            end else begin
                rdata_b_d = mem_q[bus.RADDR_B];
            end
        end
    end

    // Storage array; reset clears every word without waiting for a clock.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Read output registers; reset also cancels any read in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata_a_q  <= '0;
            rvalid_a_q <= 1'b0;
            rdata_b_q  <= '0;
            rvalid_b_q <= 1'b0;
        end else begin
            rdata_a_q  <= rdata_a_d;
            rvalid_a_q <= rvalid_a_d;
            rdata_b_q  <= rdata_b_d;
            rvalid_b_q <= rvalid_b_d;
        end
    end

    assign bus.RDATA_A  = rdata_a_q;
    assign bus.RVALID_A = rvalid_a_q;
    assign bus.RDATA_B  = rdata_b_q;
    assign bus.RVALID_B = rvalid_b_q;
endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file. Two instances share one stimulus stream:
// u_dut0 with ZERO_R0=0 and u_dut1 with ZERO_R0=1, so word-0 behaviour of
// both variants is compared against hand-computed values.
module tb_reg_file;
    logic CLK;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    reg_file_if #(.WIDTH(8), .AW(3)) bif0 ();
    reg_file_if #(.WIDTH(8), .AW(3)) bif1 ();

    assign bif1.WE      = bif0.WE;
    assign bif1.WADDR   = bif0.WADDR;
    assign bif1.WDATA   = bif0.WDATA;
    assign bif1.RE_A    = bif0.RE_A;
    assign bif1.RADDR_A = bif0.RADDR_A;
    assign bif1.RE_B    = bif0.RE_B;
    assign bif1.RADDR_B = bif0.RADDR_B;

    reg_file #(.WIDTH(8), .AW(3), .ZERO_R0(0)) u_dut0 (
        .CLK (CLK),
        .RST (RST),
        .bus (bif0)
    );

    reg_file #(.WIDTH(8), .AW(3), .ZERO_R0(1)) u_dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (bif1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check both ports of both instances against one expectation set.
    task automatic chk_all(input string tag,
                           input logic [7:0] a0, input logic va0,
                           input logic [7:0] b0, input logic vb0,
                           input logic [7:0] a1, input logic va1,
                           input logic [7:0] b1, input logic vb1);
        chk({tag, " d0.RDATA_A"},  bif0.RDATA_A,          a0);
        chk({tag, " d0.RVALID_A"}, {7'd0, bif0.RVALID_A}, {7'd0, va0});
        chk({tag, " d0.RDATA_B"},  bif0.RDATA_B,          b0);
        chk({tag, " d0.RVALID_B"}, {7'd0, bif0.RVALID_B}, {7'd0, vb0});
        chk({tag, " d1.RDATA_A"},  bif1.RDATA_A,          a1);
        chk({tag, " d1.RVALID_A"}, {7'd0, bif1.RVALID_A}, {7'd0, va1});
        chk({tag, " d1.RDATA_B"},  bif1.RDATA_B,          b1);
        chk({tag, " d1.RVALID_B"}, {7'd0, bif1.RVALID_B}, {7'd0, vb1});
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bif0.WE      = 1'b0;
        bif0.WADDR   = 3'd0;
        bif0.WDATA   = 8'h00;
        bif0.RE_A    = 1'b0;
        bif0.RADDR_A = 3'd0;
        bif0.RE_B    = 1'b0;
        bif0.RADDR_B = 3'd0;
    endtask

    initial begin
        idle();
        RST = 1'b1;
        #12;
        chk_all("reset", 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        step();
        RST = 1'b0;

        // 1: fill with 0xFF, read, then async reset between edges
        for (int i = 0; i < 8; i++) begin
            bif0.WE    = 1'b1;
            bif0.WADDR = 3'(i);
            bif0.WDATA = 8'hFF;
            step();
        end
        idle();
        bif0.RE_A = 1'b1; bif0.RADDR_A = 3'd7;
        bif0.RE_B = 1'b1; bif0.RADDR_B = 3'd0;
        step();
        chk_all("fill", 8'hFF, 1'b1, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b1);
        idle();
        #2 RST = 1'b1;
        #1;
        chk_all("async_rst", 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        #1 RST = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bif0.RE_A = 1'b1; bif0.RADDR_A = 3'(i);
            bif0.RE_B = 1'b1; bif0.RADDR_B = 3'(7 - i);
            step();
            chk_all("post_rst_read", 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1);
        end
        idle();
        step();

        // 2: write then read with one-cycle latency, then hold
        bif0.WE = 1'b1; bif0.WADDR = 3'd5; bif0.WDATA = 8'hA5;
        step();
        idle();
        bif0.RE_A = 1'b1; bif0.RADDR_A = 3'd5;
        step();
        chk_all("wr_rd", 8'hA5, 1'b1, 8'h00, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0);
        idle();
        step();
        chk_all("rd_hold", 8'hA5, 1'b0, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0);

        // 3: same-edge write forwarding on port B
        bif0.WE = 1'b1; bif0.WADDR = 3'd3; bif0.WDATA = 8'h11;
        step();
        bif0.WDATA = 8'h22;
        bif0.RE_B = 1'b1; bif0.RADDR_B = 3'd3;
        step();
        chk_all("bypass", 8'hA5, 1'b0, 8'h22, 1'b1, 8'hA5, 1'b0, 8'h22, 1'b1);
        bif0.WE = 1'b0;
        step();
        chk_all("bypass_stored", 8'hA5, 1'b0, 8'h22, 1'b1, 8'hA5, 1'b0, 8'h22, 1'b1);

        // 4: dual port, distinct then shared address, held RE tracks address
        idle();
        bif0.WE = 1'b1; bif0.WADDR = 3'd1; bif0.WDATA = 8'h0F;
        step();
        bif0.WADDR = 3'd6; bif0.WDATA = 8'hF0;
        step();
        idle();
        bif0.RE_A = 1'b1; bif0.RADDR_A = 3'd1;
        bif0.RE_B = 1'b1; bif0.RADDR_B = 3'd6;
        step();
        chk_all("dual", 8'h0F, 1'b1, 8'hF0, 1'b1, 8'h0F, 1'b1, 8'hF0, 1'b1);
        bif0.RADDR_A = 3'd6;
        step();
        chk_all("dual_same", 8'hF0, 1'b1, 8'hF0, 1'b1, 8'hF0, 1'b1, 8'hF0, 1'b1);
        bif0.RADDR_A = 3'd3; bif0.RADDR_B = 3'd5;
        bif0.WE = 1'b1; bif0.WADDR = 3'd2; bif0.WDATA = 8'h99;
        step();
        chk_all("no_false_fwd", 8'h22, 1'b1, 8'hA5, 1'b1, 8'h22, 1'b1, 8'hA5, 1'b1);

        // 5: word 0 with forwarding on both ports
        idle();
        bif0.WE = 1'b1; bif0.WADDR = 3'd0; bif0.WDATA = 8'h7E;
        bif0.RE_A = 1'b1; bif0.RADDR_A = 3'd0;
        bif0.RE_B = 1'b1; bif0.RADDR_B = 3'd0;
        step();
        chk_all("r0_bypass", 8'h7E, 1'b1, 8'h7E, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1);
        bif0.WE = 1'b0;
        step();
        chk_all("r0_stored", 8'h7E, 1'b1, 8'h7E, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1);

        // 6: reset while a read is in flight, and with a request at the edge
        idle();
        bif0.RE_A = 1'b1; bif0.RADDR_A = 3'd5;
        step();
        chk_all("pre_rst", 8'hA5, 1'b1, 8'h7E, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0);
        bif0.RE_A = 1'b0;
        #2 RST = 1'b1;
        #1;
        chk_all("midread_rst", 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        #1 RST = 1'b0;
        step();
        step();
        chk_all("rst_quiet", 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        bif0.RE_A = 1'b1; bif0.RADDR_A = 3'd5;
        bif0.WE = 1'b1; bif0.WADDR = 3'd4; bif0.WDATA = 8'h44;
        RST = 1'b1;
        step();
        idle();
        RST = 1'b0;
        step();
        chk_all("rst_drop", 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        bif0.RE_A = 1'b1; bif0.RADDR_A = 3'd4;
        step();
        chk_all("rst_no_write", 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
